// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between the bridge/decoder (master) and apb_mem_slave (slave).
// Clock and reset are not part of the bundle; they stay plain module ports.
interface apb_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   P_addr;
    logic                    P_selx;
    logic                    P_enable;
    logic                    P_write;
    logic [DATA_WIDTH-1:0]   P_wdata;
    logic [DATA_WIDTH/8-1:0] P_strb;
    logic                    P_ready;
    logic                    P_slverr;
    logic [DATA_WIDTH-1:0]   P_rdata;

    modport master (
        output P_addr, P_selx, P_enable, P_write, P_wdata, P_strb,
        input  P_ready, P_slverr, P_rdata
    );

    modport slave (
        input  P_addr, P_selx, P_enable, P_write, P_wdata, P_strb,
        output P_ready, P_slverr, P_rdata
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB slave backed by a DEPTH x DATA_WIDTH register file with byte strobes and fixed wait states.
// Define APB_MEM_SLVERR_EN to flag out-of-range or misaligned accesses with P_slverr.
module apb_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic           P_clk,
    input  logic           P_rst,
    apb_mem_slave_if.slave apb
);
    localparam int         NB        = DATA_WIDTH / 8;
    localparam int         OFFS      = $clog2(NB);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_e;
    typedef logic [DATA_WIDTH-1:0] word_t;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             slverr_q, slverr_d;
    word_t            rdata_q, rdata_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             write_q, write_d;
    word_t            wdata_q, wdata_d;
    logic [NB-1:0]    strb_q, strb_d;
    logic             mem_we;
    word_t            mem [DEPTH];

    logic [IDX_W-1:0] setup_idx;
    logic             setup_err;

    // Truncating the shifted address gives the wrap-around index for free.
    assign setup_idx = IDX_W'(apb.P_addr >> OFFS);

`ifdef APB_MEM_SLVERR_EN
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << OFFS) - 1);
    assign setup_err = (|(apb.P_addr & LOW_MASK)) || ((apb.P_addr >> (OFFS + IDX_W)) != '0);
`else
    assign setup_err = 1'b0;
`endif

    function automatic word_t read_word(input logic [IDX_W-1:0] idx, input logic err);
        return err ? '0 : mem[idx];
    endfunction

    // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        slverr_d = slverr_q;
        rdata_d  = rdata_q;
        idx_d    = idx_q;
        err_d    = err_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (apb.P_selx && !apb.P_enable) begin
                    idx_d   = setup_idx;
                    err_d   = setup_err;
                    write_d = apb.P_write;
                    wdata_d = apb.P_wdata;
                    strb_d  = apb.P_strb;
                    cnt_d   = WAIT_LOAD;
                    state_d = ACCESS;
                    if (WAIT_STATES == 0) begin
                        ready_d  = 1'b1;
                        slverr_d = setup_err;
                        if (!apb.P_write) rdata_d = read_word(setup_idx, setup_err);
                    end
                end
            end
            ACCESS: begin
                if (!(apb.P_selx && apb.P_enable)) begin
                    // Master abandoned the transfer: drop it without touching memory.
                    state_d  = IDLE;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                    cnt_d    = '0;
                end else if (ready_q) begin
                    mem_we   = write_q && !err_q;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                    state_d  = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        ready_d  = 1'b1;
                        slverr_d = err_q;
                        if (!write_q) rdata_d = read_word(idx_q, err_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; contents are undefined until written.
    always_ff @(posedge P_clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (strb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

    assign apb.P_ready  = ready_q;
    assign apb.P_slverr = slverr_q;
    assign apb.P_rdata  = rdata_q;
endmodule
